cw_mem_target: RTL

- Synthesizable CW-bus target (slave) that sits directly downstream of the core's CW master pins.
- Decodes CW request words, performs single or burst reads and writes against a synchronous SRAM-style memory port, and drives ack/err back to the master.
- Serves as the external boot/instruction memory in FPGA and test harnesses, replacing hand-written ack sequences.

---
 rtl/cw_mem_target.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cw_mem_target.sv
// CW-bus memory target: decodes request words and runs single/burst reads and writes
// against a synchronous SRAM-style port, returning ack/err pulses to the master.
module cw_mem_target #(
    parameter logic [7:0] ADDR_HI_MATCH = 8'h00,
    parameter logic [7:0] ADDR_HI_MASK  = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cw_req,
    input  logic        i_cw_dir,
    input  logic [15:0] i_cw_data,
    output logic [15:0] o_cw_data,
    output logic        o_cw_drive,
    output logic        o_cw_ack,
    output logic        o_cw_err,
    output logic [23:0] o_mem_addr,
    output logic        o_mem_re,
    input  logic [15:0] i_mem_rdata,
    output logic        o_mem_we,
    output logic [15:0] o_mem_wdata,
    input  logic        i_mem_err
);

    localparam logic [3:0] OpRead  = 4'd1;
    localparam logic [3:0] OpWrite = 4'd2;

    typedef enum logic [3:0] {
        StIdle, StAddr, StAckAddr, StTurn, StRdFetch,
        StRdAck, StWrBeat, StWrAck, StErr, StDone
    } state_e;

    state_e      state_q;
    logic [23:0] addr_q;
    logic [3:0]  op_q;
    logic [2:0]  count_q;
    logic [15:0] cw_data_q;
    logic        hit;

    assign hit = ((addr_q[23:16] ^ ADDR_HI_MATCH) & ADDR_HI_MASK) == 8'h00;

    // Any state inside a transaction falls back to idle if the master withdraws req.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            op_q      <= '0;
            count_q   <= '0;
            cw_data_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_cw_req) begin
                        addr_q[23:16] <= i_cw_data[15:8];
                        op_q          <= i_cw_data[7:4];
                        count_q       <= i_cw_data[2:0];
                        state_q       <= StAddr;
                    end
                end
                StAddr: begin
                    if (!i_cw_req) begin
                        state_q <= StIdle;
                    end else begin
                        addr_q[15:0] <= i_cw_data;
                        if (!hit) begin
                            state_q <= StDone;
                        end else if (op_q != OpRead && op_q != OpWrite) begin
                            state_q <= StErr;
                        end else begin
                            state_q <= StAckAddr;
                        end
                    end
                end
                StAckAddr: begin
                    if (!i_cw_req) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= (op_q == OpRead) ? StTurn : StWrBeat;
                    end
                end
                StTurn: begin
                    if (!i_cw_req) begin
                        state_q <= StIdle;
                    end else if (i_cw_dir) begin
                        state_q <= StRdFetch;
                    end
                end
                StRdFetch: begin
                    if (!i_cw_req) begin
                        state_q <= StIdle;
                    end else if (i_cw_dir) begin
                        cw_data_q <= i_mem_rdata;
                        state_q   <= i_mem_err ? StErr : StRdAck;
                    end
                end
                StRdAck: begin
                    if (!i_cw_req) begin
                        state_q <= StIdle;
                    end else if (i_cw_dir) begin
                        addr_q <= addr_q + 24'd1;
                        if (count_q == 3'd0) begin
                            state_q <= StDone;
                        end else begin
                            count_q <= count_q - 3'd1;
                            state_q <= StRdFetch;
                        end
                    end
                end
                StWrBeat: begin
                    if (!i_cw_req) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= i_mem_err ? StErr : StWrAck;
                    end
                end
                StWrAck: begin
                    if (!i_cw_req) begin
                        state_q <= StIdle;
                    end else begin
                        addr_q <= addr_q + 24'd1;
                        if (count_q == 3'd0) begin
                            state_q <= StDone;
                        end else begin
                            count_q <= count_q - 3'd1;
                            state_q <= StWrBeat;
                        end
                    end
                end
                StErr: begin
                    state_q <= StDone;
                end
                StDone: begin
                    if (!i_cw_req) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_cw_ack = i_cw_req && ((state_q == StAckAddr) || (state_q == StWrAck) ||
                                   ((state_q == StRdAck) && i_cw_dir));
    assign o_cw_err   = (state_q == StErr);
    assign o_cw_drive = i_cw_dir && ((state_q == StRdFetch) || (state_q == StRdAck));
    assign o_cw_data  = cw_data_q;

    // The next beat's read is launched from the ack cycle, so it must see the advanced address.
    assign o_mem_re = i_cw_req && i_cw_dir &&
                      ((state_q == StTurn) || ((state_q == StRdAck) && (count_q != 3'd0)));
    assign o_mem_addr  = (state_q == StRdAck) ? addr_q + 24'd1 : addr_q;
    assign o_mem_we    = i_cw_req && (state_q == StWrBeat);
    assign o_mem_wdata = o_mem_we ? i_cw_data : 16'h0000;

endmodule
